arm_pipe_hazard_ctrl: RTL
=========================

# arm_pipe_hazard_ctrl

Pipelined control unit with hazard resolution for the 5-stage ARM core. It takes decoded control fields from Decode and carries them through Execute, Memory and Writeback. It evaluates condition codes and maintains the NZCV flags in Execute. It also generates the stall, flush and forwarding signals, so the processor can run dependent instruction streams without software NOPs. The width of the generic pass-through control bundle and the register-address width are parameters.

## Interface
- CTRL_W, 4: width of the opaque control bundle carried D→E (ALUSrc, ALUControl[2:0] in the default core).
- REG_AW, 4: register address width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock and reset for the whole block.
- CondD  in  4  instruction condition field.
- FlagWriteD  in  2  [1] writes NZ, [0] writes CV.
- PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD  in  1 each  decoded controls.
- CtrlD  in  CTRL_W  pass-through controls.
- RA1D, RA2D, WA3D  in  REG_AW  source and destination register addresses.
- ALUFlagsE  in  4  NZCV produced by the ALU in Execute.
- CtrlE  out  CTRL_W  Execute-stage controls.
- MemWriteM  out  1; RegWriteW, MemtoRegW, PCSrcW  out  1 each.
- WA3W  out  REG_AW  writeback address.
- BranchTakenE  out  1  Execute-stage branch redirect.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- StallF, StallD, FlushD, FlushE  out  1 each  datapath pipeline-register controls.
- Flags  out  4  architectural NZCV.

## Operation
- Pipeline registers: D→E, E→M, M→W. Each holds the control bits and register addresses needed downstream.
- Condition check uses CondE against Flags:
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V.
  - HI = C&!Z; LS = !C|Z.
  - GE = N==V; LT = N!=V.
  - GT = !Z&(N==V); LE = Z|(N!=V).
  - AL = 1; 4'b1111 is treated as AL.
- CondExE gates the E→M write enables: PCSrcE, RegWriteE, MemWriteE. FlagWriteE bits are also gated by CondExE, and each gated bit loads the corresponding half of Flags from ALUFlagsE at the clock edge.
- BranchTakenE = BranchE & CondExE.
- Load-use: ldrStall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- PCWrPending = PCSrcD | PCSrcE | PCSrcM. This covers in-flight writes to R15.
- Hazard outputs:
  - StallF = ldrStall | PCWrPending.
  - StallD = ldrStall.
  - FlushD = PCWrPending | PCSrcW | BranchTakenE.
  - FlushE = ldrStall | BranchTakenE.
- Forwarding for A (B is symmetric with RA2E):
  - ForwardAE = 10 if RegWriteM & WA3M==RA1E.
  - Otherwise ForwardAE = 01 if RegWriteW & WA3W==RA1E.
  - Otherwise 00. M has priority over W.
- FlushE at a clock edge loads a bubble into D→E: all write enables, BranchD, FlagWrite and CtrlD cleared to 0.
- StallD: the D→E register still loads the bubble produced by FlushE; the controller holds no Decode state of its own.

## Timing
- Reset (synchronous, active-high): every pipeline register cleared, Flags = 0000. All outputs then read 0, so the pipeline holds bubbles.
- Update priority at each edge: reset > flush > normal load.
- Control latencies from Decode: one cycle to E, two to M, three to W.
- Flags and BranchTakenE: flags update at the end of E. An instruction in E sees flags written by the instruction ahead of it, with no bypass.
- Stall and forward outputs are combinational from current pipeline state within the same cycle.
- Simultaneous ldrStall and BranchTakenE: the branch wins. FlushD and FlushE are both asserted and StallD is still asserted; D is flushed anyway.
- Reset mid-stall: the stall is released on the next cycle.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding exactly as described in Operation.
- HAZARD_FORWARDING_EN undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - RAW hazards are resolved by stalling. rawStall = (RegWriteE & WA3E matches RA1D/RA2D) | (RegWriteM & WA3M matches RA1D/RA2D).
  - rawStall replaces ldrStall in every equation. W-stage hazards rely on the register file's write-first behaviour.

## Test plan
- Reset held for 2 cycles, then released → all outputs 0 and Flags = 0000. An ADD R1 entering D reaches RegWriteW=1, WA3W=1 three cycles later.
- ADD R1 then SUB R2,R1 back-to-back → ForwardAE=10 in the SUB's E cycle. Inserting one unrelated instruction between them → ForwardAE=01. With the macro undefined → stall cycles of 2 and 1 respectively.
- LDR R3 then ADD R4,R3 → one cycle with StallF=StallD=FlushE=1, then ForwardBE=01.
- CMP setting Z=1 (ALUFlagsE=0100, FlagWriteE=11), then BEQ → BranchTakenE=1 and FlushD=FlushE=1. The same sequence with BNE → BranchTakenE=0 and no flush.
- SUBNE with Z=1 → RegWriteM=0 and Flags unchanged.
- Write to R15 (PCSrcD=1) → StallF=1 and FlushD=1 for 3 cycles; FlushD=1 again on PCSrcW, then both deassert.

Source files
------------

// File: rtl/arm_pipe_hazard_ctrl.sv
// ARM 5-stage pipeline control: D->E->M->W control registers, NZCV, hazards.
// HAZARD_FORWARDING_EN selects bypass forwarding; undefined resolves RAW by stalling.
module arm_pipe_hazard_ctrl #(
    parameter int CTRL_W = 4,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWriteD,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic              BranchD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic [3:0]        ALUFlagsE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic              MemWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              PCSrcW,
    output logic [REG_AW-1:0] WA3W,
    output logic              BranchTakenE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [3:0]        Flags
);

    typedef struct packed {
        logic [3:0]        cond;
        logic [1:0]        fw;
        logic              pcsrc;
        logic              regwrite;
        logic              memwrite;
        logic              memtoreg;
        logic              branch;
        logic [CTRL_W-1:0] ctrl;
`ifdef HAZARD_FORWARDING_EN
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
`endif
        logic [REG_AW-1:0] wa3;
    } de_t;

    typedef struct packed {
        logic              pcsrc;
        logic              regwrite;
        logic              memwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] wa3;
    } em_t;

    typedef struct packed {
        logic              pcsrc;
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] wa3;
    } mw_t;

    de_t        de_q, de_d;
    em_t        em_q, em_d;
    mw_t        mw_q, mw_d;
    logic [3:0] flags_q, flags_d;
    logic       condex;
    logic       hz_stall;
    logic       pc_pend;
    logic [1:0] fw_g;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Condition evaluation of the Execute instruction against current flags
    always_comb begin
        case (de_q.cond)
            4'h0:    condex = z;
            4'h1:    condex = !z;
            4'h2:    condex = c;
            4'h3:    condex = !c;
            4'h4:    condex = n;
            4'h5:    condex = !n;
            4'h6:    condex = v;
            4'h7:    condex = !v;
            4'h8:    condex = c & !z;
            4'h9:    condex = !c | z;
            4'ha:    condex = (n == v);
            4'hb:    condex = (n != v);
            4'hc:    condex = !z & (n == v);
            4'hd:    condex = z | (n != v);
            default: condex = 1'b1;
        endcase
    end

    // Stall and forwarding decisions from current pipeline occupancy
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
`ifdef HAZARD_FORWARDING_EN
        hz_stall = de_q.memtoreg & de_q.regwrite &
                   ((de_q.wa3 == RA1D) | (de_q.wa3 == RA2D));
        if (em_q.regwrite && em_q.wa3 == de_q.ra1)
            ForwardAE = 2'b10;
        else if (mw_q.regwrite && mw_q.wa3 == de_q.ra1)
            ForwardAE = 2'b01;
        if (em_q.regwrite && em_q.wa3 == de_q.ra2)
            ForwardBE = 2'b10;
        else if (mw_q.regwrite && mw_q.wa3 == de_q.ra2)
            ForwardBE = 2'b01;
`else
        hz_stall = (de_q.regwrite &
                    ((de_q.wa3 == RA1D) | (de_q.wa3 == RA2D))) |
                   (em_q.regwrite &
                    ((em_q.wa3 == RA1D) | (em_q.wa3 == RA2D)));
`endif
    end

    assign pc_pend      = PCSrcD | de_q.pcsrc | em_q.pcsrc;
    assign BranchTakenE = de_q.branch & condex;
    assign StallF       = hz_stall | pc_pend;
    assign StallD       = hz_stall;
    assign FlushD       = pc_pend | mw_q.pcsrc | BranchTakenE;
    assign FlushE       = hz_stall | BranchTakenE;
    assign fw_g         = de_q.fw & {2{condex}};

    // Next-state: bubble on FlushE, condition-gated enables into Memory
    always_comb begin
        de_d = '0;
        if (!FlushE) begin
            de_d.cond     = CondD;
            de_d.fw       = FlagWriteD;
            de_d.pcsrc    = PCSrcD;
            de_d.regwrite = RegWriteD;
            de_d.memwrite = MemWriteD;
            de_d.memtoreg = MemtoRegD;
            de_d.branch   = BranchD;
            de_d.ctrl     = CtrlD;
`ifdef HAZARD_FORWARDING_EN
            de_d.ra1      = RA1D;
            de_d.ra2      = RA2D;
`endif
            de_d.wa3      = WA3D;
        end
        em_d.pcsrc    = de_q.pcsrc & condex;
        em_d.regwrite = de_q.regwrite & condex;
        em_d.memwrite = de_q.memwrite & condex;
        em_d.memtoreg = de_q.memtoreg;
        em_d.wa3      = de_q.wa3;
        mw_d.pcsrc    = em_q.pcsrc;
        mw_d.regwrite = em_q.regwrite;
        mw_d.memtoreg = em_q.memtoreg;
        mw_d.wa3      = em_q.wa3;
        flags_d[3:2]  = fw_g[1] ? ALUFlagsE[3:2] : flags_q[3:2];
        flags_d[1:0]  = fw_g[0] ? ALUFlagsE[1:0] : flags_q[1:0];
    end

    // Pipeline registers and flags with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            de_q    <= '0;
            em_q    <= '0;
            mw_q    <= '0;
            flags_q <= '0;
        end else begin
            de_q    <= de_d;
            em_q    <= em_d;
            mw_q    <= mw_d;
            flags_q <= flags_d;
        end
    end

    assign CtrlE     = de_q.ctrl;
    assign MemWriteM = em_q.memwrite;
    assign RegWriteW = mw_q.regwrite;
    assign MemtoRegW = mw_q.memtoreg;
    assign PCSrcW    = mw_q.pcsrc;
    assign WA3W      = mw_q.wa3;
    assign Flags     = flags_q;

endmodule
